// File: rtl/pd_dw_nr_rd_arb.sv
// PD result RAM read arbiter: streams the full RAM after each frame
// and interleaves single-word CPU reads on the same read port.
module pd_dw_nr_rd_arb #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 48,
  parameter int SYMB_NUM   = 280,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              i_dump_en,
  input  logic              i_frame_done,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_ram_re,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_sop,
  output logic              o_dump_eop,
  output logic              o_busy,
  output logic              o_ovf
);

  localparam int DUMP_N = SYMB_NUM * 4;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DUMP_N - 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DUMP, DRAIN} state_t;

  state_t state, state_nxt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [RAM_LAT-1:0] tag_v, tag_cpu, tag_sop, tag_eop;
  logic last_cpu;
  logic [DATA_W+1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fcnt;
  logic cpu_pend, dump_elig, cpu_gnt, dump_gnt;
  logic push, pop, ret_cpu;
  logic [DATA_W+1:0] head;
  int used;

  assign o_busy       = (state != IDLE);
  assign o_dump_valid = (fcnt != '0);
  assign head         = o_dump_valid ? fifo_mem[rd_ptr] : '0;
  assign o_dump_eop   = head[DATA_W+1];
  assign o_dump_sop   = head[DATA_W];
  assign o_dump_data  = head[DATA_W-1:0];
  assign push    = tag_v[RAM_LAT-1] && !tag_cpu[RAM_LAT-1];
  assign ret_cpu = tag_v[RAM_LAT-1] && tag_cpu[RAM_LAT-1];
  assign pop     = o_dump_valid && i_dump_ready;

  // Credits: dump reads in flight plus buffered words bound FIFO use
  always_comb begin
    used = int'(fcnt);
    for (int i = 0; i < RAM_LAT; i++)
      if (tag_v[i] && !tag_cpu[i]) used = used + 1;
    cpu_pend  = i_cpu_req && !(|(tag_v & tag_cpu)) && !o_cpu_ack;
    dump_elig = (state == DUMP) && (used < FIFO_DEPTH);
    cpu_gnt   = cpu_pend && !(last_cpu && dump_elig);
    dump_gnt  = dump_elig && !cpu_gnt;
    o_ram_re  = cpu_gnt || dump_gnt;
    o_ram_addr = '0;
    if (cpu_gnt)       o_ram_addr = i_cpu_addr;
    else if (dump_gnt) o_ram_addr = rd_cnt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (i_frame_done && i_dump_en) state_nxt = DUMP;
      DUMP:  if (dump_gnt && rd_cnt == LAST) state_nxt = DRAIN;
      DRAIN: if (pop && o_dump_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      last_cpu <= 1'b0;
      tag_v    <= '0;
      tag_cpu  <= '0;
      tag_sop  <= '0;
      tag_eop  <= '0;
      o_ovf    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_cpu <= cpu_gnt;
      o_ovf    <= i_frame_done && i_dump_en && o_busy;
      if (state == IDLE && state_nxt == DUMP) rd_cnt <= '0;
      else if (dump_gnt && rd_cnt != LAST) rd_cnt <= rd_cnt + ADDR_W'(1);
      for (int i = RAM_LAT - 1; i > 0; i--) begin
        tag_v[i]   <= tag_v[i-1];
        tag_cpu[i] <= tag_cpu[i-1];
        tag_sop[i] <= tag_sop[i-1];
        tag_eop[i] <= tag_eop[i-1];
      end
      tag_v[0]   <= o_ram_re;
      tag_cpu[0] <= cpu_gnt;
      tag_sop[0] <= dump_gnt && (rd_cnt == '0);
      tag_eop[0] <= dump_gnt && (rd_cnt == LAST);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      o_cpu_ack   <= 1'b0;
      o_cpu_rdata <= '0;
    end else begin
      o_cpu_ack <= ret_cpu;
      if (ret_cpu) o_cpu_rdata <= i_ram_rdata;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {tag_eop[RAM_LAT-1], tag_sop[RAM_LAT-1], i_ram_rdata};
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      fcnt <= fcnt + CW'(1);
      else if (pop && !push) fcnt <= fcnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_pd_dw_nr_rd_arb.sv
// Scoreboard bench for pd_dw_nr_rd_arb with a 2-cycle RAM model.
module tb_pd_dw_nr_rd_arb;

  logic        sys_clk = 0;
  logic        sys_rst;
  logic        i_dump_en, i_frame_done, i_cpu_req, i_dump_ready;
  logic [10:0] i_cpu_addr;
  logic        o_cpu_ack, o_ram_re, o_dump_valid;
  logic        o_dump_sop, o_dump_eop, o_busy, o_ovf;
  logic [47:0] o_cpu_rdata, i_ram_rdata, o_dump_data;
  logic [10:0] o_ram_addr;

  pd_dw_nr_rd_arb dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .i_dump_en(i_dump_en), .i_frame_done(i_frame_done),
    .i_cpu_req(i_cpu_req), .i_cpu_addr(i_cpu_addr),
    .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
    .o_ram_re(o_ram_re), .o_ram_addr(o_ram_addr),
    .i_ram_rdata(i_ram_rdata),
    .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
    .o_dump_data(o_dump_data), .o_dump_sop(o_dump_sop),
    .o_dump_eop(o_dump_eop), .o_busy(o_busy), .o_ovf(o_ovf)
  );

  always #2 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int words, ovf_cnt, rdy_mode, rdy_cyc;
  logic [49:0] dq[$];
  logic [47:0] cq[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] ram_val(input logic [10:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1;
    return {5'h15, a, h};
  endfunction

  // RAM model: address sampled at the grant edge, data one cycle later
  logic [10:0] ra1;
  always @(posedge sys_clk) begin
    ra1 <= o_ram_addr;
    i_ram_rdata <= ram_val(ra1);
  end

  initial begin
    i_dump_ready = 1;
    forever begin
      @(posedge sys_clk); #1;
      rdy_cyc++;
      if (rdy_mode == 0) i_dump_ready = 1;
      else if (rdy_cyc >= 300 && rdy_cyc < 350) i_dump_ready = 0;
      else i_dump_ready = (rdy_cyc % 3 == 0);
    end
  end

  // Output monitor
  bit          eop_prev = 0, stall_prev = 0;
  logic [49:0] stall_word;
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      eop_prev = 0;
      stall_prev = 0;
    end else begin
      if (eop_prev) chk("busy_after_eop", 64'(o_busy), 0);
      if (stall_prev)
        chk("stall_stable", {o_dump_valid, o_dump_eop, o_dump_sop, o_dump_data},
            {1'b1, stall_word});
      eop_prev = 0;
      if (o_dump_valid && i_dump_ready) begin
        if (dq.size() == 0) chk("dump_extra", 1, 0);
        else chk("dump_word", {o_dump_eop, o_dump_sop, o_dump_data}, dq.pop_front());
        words++;
        eop_prev = o_dump_eop;
      end
      stall_prev = o_dump_valid && !i_dump_ready;
      stall_word = {o_dump_eop, o_dump_sop, o_dump_data};
      if (o_cpu_ack) begin
        if (cq.size() == 0) chk("cpu_extra", 1, 0);
        else chk("cpu_data", 64'(o_cpu_rdata), 64'(cq.pop_front()));
      end
      if (o_ovf) ovf_cnt++;
    end
  end

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic frame_pulse(input bit expect_start);
    i_frame_done = 1;
    if (expect_start)
      for (int a = 0; a < 1120; a++)
        dq.push_back({a == 1119, a == 0, ram_val(11'(a))});
    tick();
    i_frame_done = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy && n < budget) begin tick(); n++; end
    if (o_busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic cpu_read(input logic [10:0] a, input bit timing);
    int n = 0;
    i_cpu_req = 1;
    i_cpu_addr = a;
    cq.push_back(ram_val(a));
    @(negedge sys_clk);
    if (timing) begin
      chk("cpu_re", 64'(o_ram_re), 1);
      chk("cpu_addr", 64'(o_ram_addr), 64'(a));
    end
    while (!o_cpu_ack && n < 40) begin @(negedge sys_clk); n++; end
    if (timing) chk("cpu_lat", 64'(n), 3);
    else if (!o_cpu_ack) chk("cpu_timeout", 1, 0);
    tick();
    i_cpu_req = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    sys_rst = 1; i_dump_en = 1; i_frame_done = 0;
    i_cpu_req = 0; i_cpu_addr = 0; rdy_mode = 0; rdy_cyc = 0;
    words = 0; ovf_cnt = 0;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_valid", 64'(o_dump_valid), 0);
    chk("rst_ack", 64'(o_cpu_ack), 0);
    chk("rst_re", 64'(o_ram_re), 0);
    chk("rst_ovf", 64'(o_ovf), 0);
    chk("rst_data", 64'(o_dump_data), 0);
    tick();
    sys_rst = 0;
    repeat (2) tick();

    // Full dump with ready held high
    frame_pulse(1);
    chk("busy_set", 64'(o_busy), 1);
    wait_idle(5000);
    chk("t1_words", 64'(words), 1120);
    chk("t1_ovf", 64'(ovf_cnt), 0);
    chk("t1_q", 64'(dq.size()), 0);

    // Single CPU read while idle
    repeat (3) tick();
    cpu_read(11'h2A7, 1);
    repeat (3) tick();

    // Frame done with dump disabled is ignored
    i_dump_en = 0;
    frame_pulse(0);
    tick();
    chk("noen_busy", 64'(o_busy), 0);
    chk("noen_ovf", 64'(ovf_cnt), 0);
    i_dump_en = 1;

    // Throttled ready with long stall; dump_en dropped mid-dump
    words = 0; rdy_cyc = 0; rdy_mode = 1;
    frame_pulse(1);
    repeat (200) tick();
    i_dump_en = 0;
    wait_idle(20000);
    i_dump_en = 1;
    rdy_mode = 0;
    chk("t3_words", 64'(words), 1120);
    chk("t3_q", 64'(dq.size()), 0);
    repeat (3) tick();

    // CPU reads interleaved with a running dump
    words = 0;
    frame_pulse(1);
    fork
      for (int k = 0; k < 12; k++) cpu_read(11'($urandom_range(0, 1119)), 0);
      wait_idle(6000);
    join
    wait_idle(6000);
    chk("t4_words", 64'(words), 1120);
    chk("t4_cq", 64'(cq.size()), 0);
    repeat (3) tick();

    // Second frame done mid-dump
    words = 0; ovf_cnt = 0;
    frame_pulse(1);
    repeat (100) tick();
    frame_pulse(0);
    wait_idle(5000);
    tick();
    chk("t5_ovf", 64'(ovf_cnt), 1);
    chk("t5_words", 64'(words), 1120);
    chk("t5_idle", 64'(o_busy), 0);
    repeat (3) tick();

    // Reset in the middle of a dump, then a fresh dump
    words = 0;
    frame_pulse(1);
    n = 0;
    while (words < 500 && n < 3000) begin tick(); n++; end
    chk("t6_reach500", 64'(words >= 500), 1);
    sys_rst = 1;
    dq.delete();
    #1;
    chk("t6_busy", 64'(o_busy), 0);
    chk("t6_valid", 64'(o_dump_valid), 0);
    tick();
    sys_rst = 0;
    repeat (2) tick();
    words = 0;
    frame_pulse(1);
    wait_idle(5000);
    chk("t6_words", 64'(words), 1120);
    chk("t6_q", 64'(dq.size()), 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pd_dw_nr_rd_arb.md
Name: pd_dw_nr_rd_arb

Overview:
- Read-port arbiter and sequencer for the PD result RAM, which holds 48-bit power sums.
- The RAM is addressed as {symbol[8:0], entry[1:0]}: 280 symbols × 4 entries = 1120 words.
- Serves two requesters:
  - a streaming dump engine that, after each frame, reads the whole RAM out in order over a valid/ready interface;
  - a single-word CPU register read port.
- Sits between the PD calc/storage block and the downstream report/DMA logic.

Parameters:
- ADDR_W, 11, RAM address width.
- DATA_W, 48, RAM data width.
- SYMB_NUM, 280, symbols per frame. Dump length is SYMB_NUM*4 words.
- RAM_LAT, 2, cycles from ram_addr/ram_re to valid ram_rdata. Fixed pipeline.
- FIFO_DEPTH, 4, dump output buffer depth. Must be ≥ RAM_LAT+1.

Ports:
- sys_clk  in  1  clock, 245.76 MHz.
- sys_rst  in  1  reset, asynchronous, active-high.
- i_dump_en  in  1  enables automatic dump on frame completion.
- i_frame_done  in  1  one-cycle pulse: last PD word of the frame has been written.
- i_cpu_req  in  1  CPU read request. Held high until o_cpu_ack.
- i_cpu_addr  in  ADDR_W  CPU read address.
- o_cpu_ack  out  1  one-cycle pulse; o_cpu_rdata is valid in the same cycle.
- o_cpu_rdata  out  DATA_W  CPU read data. Held until the next ack.
- o_ram_re  out  1  RAM read enable.
- o_ram_addr  out  ADDR_W  RAM read address.
- i_ram_rdata  in  DATA_W  RAM read data.
- o_dump_valid  out  1  dump word valid.
- i_dump_ready  in  1  downstream ready.
- o_dump_data  out  DATA_W  dump word.
- o_dump_sop  out  1  first word of dump (address 0).
- o_dump_eop  out  1  last word of dump (address SYMB_NUM*4-1).
- o_busy  out  1  dump in progress, from trigger until the eop word is accepted.
- o_ovf  out  1  one-cycle pulse: i_frame_done arrived while o_busy.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters, FIFO and tag pipe cleared. Reset mid-dump aborts the dump and empties the FIFO.
- FSM states:
  - IDLE → DUMP on i_frame_done && i_dump_en && !o_busy.
  - DUMP: issue reads; when the last address has been issued → DRAIN.
  - DRAIN → IDLE when the eop word handshakes (valid && ready).
  - o_busy = (state != IDLE).
- Dump addressing:
  - Read counter rd_cnt starts at 0 on entry to DUMP and increments per issued dump read.
  - o_ram_addr = rd_cnt for dump reads. Last address = SYMB_NUM*4-1 = 1119.
  - No wrap: the counter stops in DRAIN.
- Credit/flow control:
  - A dump read may issue only if (reads in flight + FIFO occupancy) < FIFO_DEPTH.
  - The FIFO therefore never overflows, so no read data is ever dropped.
  - The FIFO pops on valid && ready.
  - o_dump_data/sop/eop stay stable while valid && !ready.
- Arbitration, evaluated per cycle:
  - A pending CPU request has priority, except in the cycle immediately after a CPU grant, if a dump read is eligible. This guarantees ≥1 dump slot per 2 cycles.
  - A CPU request is pending when i_cpu_req is high and no CPU read is already in flight.
  - On a grant: o_ram_re=1; o_ram_addr = i_cpu_addr (CPU) or rd_cnt (dump).
- Return routing:
  - A RAM_LAT-deep tag shift register {valid, owner} routes i_ram_rdata.
  - CPU-owned return: register i_ram_rdata into o_cpu_rdata and pulse o_cpu_ack, RAM_LAT+1 cycles after the grant.
  - Dump-owned return: push {data, sop=(addr==0), eop=(addr==last)} into the FIFO.
- CPU accesses are accepted in any state, including during a dump; CPU reads do not disturb dump order.
- Frame-done handling:
  - i_frame_done while o_busy: o_ovf pulses for 1 cycle; the trigger is ignored and the current dump continues.
  - i_frame_done with i_dump_en=0: ignored, no o_ovf.
  - Deasserting i_dump_en mid-dump does not abort; the dump completes.
- Simultaneous i_frame_done and the eop handshake in the same cycle: treated as busy, so o_ovf pulses and no new dump starts.

Test Plan:
- Frame done, dump_en=1, ready always high → 1120 words in address order; sop on word 0, eop on word 1119; o_busy falls the cycle after eop; no o_ovf.
- Ready toggled 1-in-3, plus a 50-cycle stall → no lost or duplicated words; FIFO never exceeds 4; data stable while stalled.
- CPU read of addr 0x2A7 in IDLE → o_ram_re with addr 0x2A7 at grant; o_cpu_ack at grant+3 with RAM content.
- CPU reads back-to-back during a dump with ready high → CPU and dump grants alternate; every CPU ack returns correct data; dump order intact.
- Second i_frame_done mid-dump → o_ovf single pulse; exactly 1120 words out; FSM returns to IDLE.
- sys_rst asserted at dump word 500, then released, then frame done → o_busy/valid drop immediately; the new dump restarts at address 0 with sop.
